// File: rtl/ahb_cmd_sequencer.sv
// rtl/ahb_cmd_sequencer.sv - queued command front-end issuing one transaction at a time to the AHB-to-SPI bridge (optional timeout: AHB_SEQ_TIMEOUT_EN)
module ahb_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     HCLK,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_addr,
  input  logic [2:0]               cmd_size,
  input  logic                     cmd_write,
  input  logic [2:0]               cmd_burst,
  output logic [7:0]               addr,
  output logic [2:0]               size,
  output logic                     write,
  output logic [2:0]               burst,
  output logic                     start,
  input  logic                     done,
  input  logic [31:0]              HRDATA,
  input  logic                     HRESP,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ahb_cmd_sequencer: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ahb_cmd_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [14:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [14:0]     w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_timeout;

  logic [7:0]      r_addr;
  logic [2:0]      r_size;
  logic            r_write;
  logic [2:0]      r_burst;
  logic            r_sticky_err;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_err;

  assign cmd_ready = (r_count != CW'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign cmd_count = r_count;

  assign addr     = r_addr;
  assign size     = r_size;
  assign write    = r_write;
  assign burst    = r_burst;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

  // FIFO storage: contents need no reset, emptiness is tracked by the count
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_addr, cmd_size, cmd_write, cmd_burst};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; done during ISSUE is deliberately not looked at
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0)        w_next = S_ISSUE;
      S_ISSUE:                           w_next = S_WAIT;
      S_WAIT:  if (done || w_timeout)    w_next = S_RESP;
      S_RESP:  if (rsp_ready)            w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    start     = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    start     = (r_state == S_ISSUE);
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

  // Bridge command registers, loaded on pop and held until the next pop
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_burst <= '0;
    end else if (w_pop) begin
      r_addr  <= w_head[14:7];
      r_size  <= w_head[6:4];
      r_write <= w_head[3];
      r_burst <= w_head[2:0];
    end
  end

  // Response capture: sticky error across WAIT, data/error latched on done
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      r_sticky_err <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else if (w_pop) begin
      r_sticky_err <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (done) begin
        r_rsp_data <= r_write ? 32'h0 : HRDATA;
        r_rsp_err  <= r_sticky_err | HRESP;
      end else if (w_timeout) begin
        r_rsp_data <= 32'h0;
        r_rsp_err  <= 1'b1;
      end else if (HRESP) begin
        r_sticky_err <= 1'b1;
      end
    end
  end

`ifdef AHB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wait_cnt;
  logic          r_rsp_timeout;

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a done in that same cycle wins
  assign w_timeout   = (r_state == S_WAIT) && !done &&
                       (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = r_rsp_timeout;

  // WAIT cycle counter, cleared in ISSUE so it starts at zero on WAIT entry
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst)                     r_wait_cnt <= '0;
    else if (r_state == S_ISSUE) r_wait_cnt <= '0;
    else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + TW'(1);
  end

  // Timeout flag, cleared with the other flags on pop
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst)            r_rsp_timeout <= 1'b0;
    else if (w_pop)     r_rsp_timeout <= 1'b0;
    else if (w_timeout) r_rsp_timeout <= 1'b1;
  end
`else
  assign w_timeout   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// tb/tb_ahb_cmd_sequencer.sv - directed self-checking bench for ahb_cmd_sequencer (timeout section under AHB_SEQ_TIMEOUT_EN)
module tb_ahb_cmd_sequencer;

  logic        HCLK;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [2:0]  cmd_size;
  logic        cmd_write;
  logic [2:0]  cmd_burst;
  logic [7:0]  addr;
  logic [2:0]  size;
  logic        write;
  logic [2:0]  burst;
  logic        start;
  logic        done;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [2:0]  cmd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;

  ahb_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_write(cmd_write), .cmd_burst(cmd_burst),
    .addr(addr), .size(size), .write(write), .burst(burst), .start(start),
    .done(done), .HRDATA(HRDATA), .HRESP(HRESP),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy), .cmd_count(cmd_count)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) if (start === 1'b1) n_starts++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [2:0] s, input logic w, input logic [2:0] b);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_write = w;
    cmd_burst = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [7:0] exp_addr [10];
  int         s0;
  logic       seen_rsp;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_write = 1'b0;
    cmd_burst = '0; done = 1'b0; HRDATA = '0; HRESP = 1'b0; rsp_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_cmd_count", {29'd0, cmd_count}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Single write: start pulse exactly on the cycle after the pop edge
    push(8'h10, 3'd2, 1'b1, 3'd0);
    chk("w_count_after_push", {29'd0, cmd_count}, 32'd1);
    chk("w_no_bypass", {31'd0, start}, 32'd0);
    tick();
    chk("w_start", {31'd0, start}, 32'd1);
    chk("w_addr", {24'd0, addr}, 32'h10);
    chk("w_size", {29'd0, size}, 32'd2);
    chk("w_write", {31'd0, write}, 32'd1);
    chk("w_busy", {31'd0, busy}, 32'd1);
    repeat (5) tick();
    chk("w_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    HRDATA = 32'hCAFE_F00D;
    done = 1'b1;
    tick();
    done = 1'b0; HRDATA = '0;
    chk("w_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("w_rsp_data_zero", rsp_data, 32'd0);
    chk("w_rsp_err", {31'd0, rsp_err}, 32'd0);
    handshake();
    chk("w_rsp_valid_fall", {31'd0, rsp_valid}, 32'd0);
    chk("w_busy_after", {31'd0, busy}, 32'd0);
    chk("w_one_start", n_starts, 32'd1);

    // Read with data and a 5-cycle rsp_ready stall
    push(8'h24, 3'd2, 1'b0, 3'd1);
    wait_start("r_start_seen");
    tick(); tick(); tick();
    HRDATA = 32'hDEAD_BEEF;
    done = 1'b1;
    tick();
    done = 1'b0; HRDATA = '0;
    chk("r_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("r_rsp_data", rsp_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("r_stall_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("r_stall_data_%0d", i), rsp_data, 32'hDEAD_BEEF);
      chk($sformatf("r_stall_err_%0d", i), {31'd0, rsp_err}, 32'd0);
      chk($sformatf("r_stall_nostart_%0d", i), {31'd0, start}, 32'd0);
    end
    handshake();
    chk("r_two_starts", n_starts, 32'd2);

    // FIFO full and wrap: blocker in flight, then 5 pushes at DEPTH=4
    push(8'h30, 3'd0, 1'b0, 3'd0);
    wait_start("f_blocker_start");
    tick();
    for (int i = 0; i < 5; i++) begin
      push(8'h40 + 8'(i), 3'd0, 1'b0, 3'd0);
      chk($sformatf("f_count_%0d", i), {29'd0, cmd_count}, (i < 4) ? 32'(i + 1) : 32'd4);
      chk($sformatf("f_ready_%0d", i), {31'd0, cmd_ready}, (i < 3) ? 32'd1 : 32'd0);
    end
    exp_addr[0] = 8'h30;
    for (int i = 0; i < 4; i++) exp_addr[1 + i] = 8'h40 + 8'(i);
    for (int i = 0; i < 5; i++) exp_addr[5 + i] = 8'h50 + 8'(i);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        wait_start($sformatf("f_start_%0d", k));
        if (k <= 5) push(8'h50 + 8'(k - 1), 3'd0, 1'b0, 3'd0);
        else        tick();
      end
      chk($sformatf("f_addr_%0d", k), {24'd0, addr}, {24'd0, exp_addr[k]});
      HRDATA = 32'hA500_0000 | 32'(k);
      done = 1'b1;
      tick();
      done = 1'b0; HRDATA = '0;
      chk($sformatf("f_rsp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("f_rsp_data_%0d", k), rsp_data, 32'hA500_0000 | 32'(k));
      handshake();
    end
    chk("f_drained", {29'd0, cmd_count}, 32'd0);

    // Error: one-cycle HRESP mid-WAIT is sticky; write data forced to 0
    push(8'h60, 3'd2, 1'b1, 3'd0);
    wait_start("e_start");
    tick(); tick();
    HRESP = 1'b1;
    tick();
    HRESP = 1'b0;
    tick();
    HRDATA = 32'hFFFF_FFFF;
    done = 1'b1;
    tick();
    done = 1'b0; HRDATA = '0;
    chk("e_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("e_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("e_rsp_data", rsp_data, 32'd0);
    chk("e_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    handshake();

    // Clean read after error; a done in the ISSUE cycle is ignored
    push(8'h61, 3'd2, 1'b0, 3'd0);
    wait_start("c_start");
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("c_issue_done_ignored", {31'd0, rsp_valid}, 32'd0);
    chk("c_busy", {31'd0, busy}, 32'd1);
    HRDATA = 32'h1234_5678;
    done = 1'b1;
    tick();
    done = 1'b0; HRDATA = '0;
    chk("c_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("c_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("c_rsp_data", rsp_data, 32'h1234_5678);
    handshake();

    // Reset mid-WAIT with two commands queued
    push(8'h70, 3'd0, 1'b0, 3'd0);
    wait_start("x_start");
    tick();
    push(8'h71, 3'd0, 1'b0, 3'd0);
    push(8'h72, 3'd0, 1'b0, 3'd0);
    chk("x_queued", {29'd0, cmd_count}, 32'd2);
    rst = 1'b1;
    #1;
    chk("x_async_count", {29'd0, cmd_count}, 32'd0);
    chk("x_async_busy", {31'd0, busy}, 32'd0);
    chk("x_async_start", {31'd0, start}, 32'd0);
    chk("x_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("x_async_ready", {31'd0, cmd_ready}, 32'd1);
    chk("x_async_addr", {24'd0, addr}, 32'd0);
    tick();
    rst = 1'b0;
    s0 = n_starts;
    seen_rsp = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid === 1'b1 || busy === 1'b1) seen_rsp = 1'b1;
      tick();
    end
    chk("x_no_start_after", n_starts, s0);
    chk("x_no_rsp_after", {31'd0, seen_rsp}, 32'd0);

`ifdef AHB_SEQ_TIMEOUT_EN
    // Timeout after 16 WAIT cycles; late done ignored; next command runs normally
    push(8'h80, 3'd0, 1'b0, 3'd0);
    push(8'h81, 3'd0, 1'b0, 3'd0);
    wait_start("t_start");
    tick();
    for (int i = 1; i < 16; i++) tick();
    chk("t_not_yet", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("t_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("t_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    chk("t_rsp_data", rsp_data, 32'd0);
    tick(); tick();
    HRDATA = 32'h5555_AAAA;
    done = 1'b1;
    tick();
    done = 1'b0; HRDATA = '0;
    chk("t_late_done_data", rsp_data, 32'd0);
    chk("t_late_done_timeout", {31'd0, rsp_timeout}, 32'd1);
    handshake();
    wait_start("t_next_start");
    chk("t_next_addr", {24'd0, addr}, 32'h81);
    chk("t_next_flags_clear", {31'd0, rsp_timeout}, 32'd0);
    tick();
    HRDATA = 32'h0BAD_CAFE;
    done = 1'b1;
    tick();
    done = 1'b0; HRDATA = '0;
    chk("t_next_err", {31'd0, rsp_err}, 32'd0);
    chk("t_next_data", rsp_data, 32'h0BAD_CAFE);
    handshake();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
